// File: rtl/elevator_car_drive.sv
// elevator_car_drive
//   Car/drive-side responder for the elevator controller. It takes go-to-floor
//   commands over a valid/ready handshake and moves the car one floor at a time,
//   with a fixed travel time per floor. It then runs the door sequence: open,
//   dwell, close. It also serves as the car plant model in controller-level
//   simulation.
//
// Ports
//   clock          rising-edge system clock
//   reset          synchronous, active-high; homes the car to floor 1
//   cmd_valid      command present
//   cmd_target     requested floor, 1..NUM_FLOORS (anything else is flagged)
//   cmd_ready      high only while idle; accept = cmd_valid && cmd_ready
//   cmd_err        one-cycle pulse after an illegal target was accepted
//   door_obstruct  door-edge sensor, level
//   floor_number   current floor, 1..NUM_FLOORS
//   dir            1 = up, 0 = down; holds the last travel direction
//   moving         car in motion
//   door_closed    door fully closed (idle, moving, arrival cycle)
//   door_open      door fully open (dwell)
//   arrived        one-cycle pulse when the car reaches its target

module elevator_car_drive #(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int DWELL_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_target,
  output logic       cmd_ready,
  output logic       cmd_err,
  input  logic       door_obstruct,
  output logic [2:0] floor_number,
  output logic       dir,
  output logic       moving,
  output logic       door_closed,
  output logic       door_open,
  output logic       arrived
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    ARRIVE  = 3'd2,
    OPENING = 3'd3,
    DWELL   = 3'd4,
    CLOSING = 3'd5
  } state_e;

  // Counters run from LOAD down to 0, so each phase lasts LOAD+1 cycles.
  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);
  localparam logic [7:0] DWELL_LOAD  = 8'(DWELL_CYCLES - 1);
  localparam logic [2:0] TOP_FLOOR   = 3'(NUM_FLOORS);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [2:0] floor_q, floor_d;
  logic [2:0] target_q, target_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;

  logic       accept;
  logic       targetBad;
  logic [2:0] nextFloor;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign targetBad = (cmd_target == 3'd0) || (cmd_target > TOP_FLOOR);
  // Neighbouring floor in the current travel direction. It is only used in MOVE,
  // where the target is legal, so it never leaves 1..NUM_FLOORS.
  assign nextFloor = dir_q ? (floor_q + 3'd1) : (floor_q - 3'd1);

  // State register. Reset wins over everything and drops any in-flight command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      floor_q  <= 3'd1;
      target_q <= 3'd1;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      floor_q  <= floor_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic for the car and door sequence.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    floor_d  = floor_q;
    target_d = target_q;
    dir_d    = dir_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (targetBad) begin
            err_d = 1'b1;
          end else if (cmd_target == floor_q) begin
            target_d = cmd_target;
            state_d  = ARRIVE;
          end else begin
            target_d = cmd_target;
            dir_d    = (cmd_target > floor_q);
            count_d  = TRAVEL_LOAD;
            state_d  = MOVE;
          end
        end
      end

      MOVE: begin
        if (count_q == 8'd0) begin
          floor_d = nextFloor;
          if (nextFloor == target_q) begin
            state_d = ARRIVE;
          end else begin
            count_d = TRAVEL_LOAD;
          end
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      ARRIVE: begin
        state_d = OPENING;
        count_d = DOOR_LOAD;
      end

      OPENING: begin
        if (count_q == 8'd0) begin
          state_d = DWELL;
          count_d = DWELL_LOAD;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      // An obstruction keeps restarting the full dwell time.
      DWELL: begin
        if (door_obstruct) begin
          count_d = DWELL_LOAD;
        end else if (count_q == 8'd0) begin
          state_d = CLOSING;
          count_d = DOOR_LOAD;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      // An obstruction while closing reopens the door completely.
      CLOSING: begin
        if (door_obstruct) begin
          state_d = OPENING;
          count_d = DOOR_LOAD;
        end else if (count_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  assign cmd_ready    = (state_q == IDLE);
  assign cmd_err      = err_q;
  assign floor_number = floor_q;
  assign dir          = dir_q;
  assign moving       = (state_q == MOVE);
  assign door_closed  = (state_q == IDLE) || (state_q == MOVE) || (state_q == ARRIVE);
  assign door_open    = (state_q == DWELL);
  assign arrived      = (state_q == ARRIVE);

endmodule
